mem_access_unit: RTL

Memory access stage between the multi-cycle Controller and the unified instruction/data memory. It turns the Controller's level-style MemRead/MemWrite/IorD/IRWrite commands into a req/ack transaction with variable-latency memory. It holds the Instruction Register (IR) and Memory Data Register (MDR), and decodes IR fields (OpCode, Funct, etc.) for the Controller and datapath. It raises Stall while a transaction is outstanding so the Controller can freeze its state.

---
 rtl/cpu_pkg.sv | 43 ++++
 rtl/mau_watchdog.sv | 41 ++++
 rtl/mem_access_unit.sv | 133 +++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: memory-access FSM states, access kinds and the
// instruction-register field positions used by the Controller and datapath.
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } mau_state_t;

    typedef enum logic [1:0] {
        ACC_WR  = 2'd0,
        ACC_IR  = 2'd1,
        ACC_MDR = 2'd2
    } acc_kind_t;

    // Instruction register field bit positions
    localparam int IR_OP_HI    = 31;
    localparam int IR_OP_LO    = 26;
    localparam int IR_RS_HI    = 25;
    localparam int IR_RS_LO    = 21;
    localparam int IR_RT_HI    = 20;
    localparam int IR_RT_LO    = 16;
    localparam int IR_RD_HI    = 15;
    localparam int IR_RD_LO    = 11;
    localparam int IR_SHAMT_HI = 10;
    localparam int IR_SHAMT_LO = 6;
    localparam int IR_FUNCT_HI = 5;
    localparam int IR_FUNCT_LO = 0;
    localparam int IR_IMM_HI   = 15;
    localparam int IR_JT_HI    = 25;

    // A write always wins over a simultaneous read; IRWrite only steers reads.
    function automatic acc_kind_t decode_kind(input logic mem_write, input logic ir_write);
        if (mem_write)
            return ACC_WR;
        else if (ir_write)
            return ACC_IR;
        else
            return ACC_MDR;
    endfunction

endpackage

// File: rtl/mau_watchdog.sv
// Request watchdog for mem_access_unit: counts cycles spent waiting for
// mem_ack and flags a timeout once TIMEOUT_CYCLES request cycles have
// passed without one. The error flag is sticky until reset.
module mau_watchdog #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic in_req,
    input  logic ack,
    output logic timeout,
    output logic err
);

    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [CNT_W-1:0] cnt;

    // cnt holds (request cycles already elapsed); the last allowed cycle is
    // the one where cnt equals TIMEOUT_CYCLES-1. An ack in that cycle wins.
    assign timeout = in_req && !ack && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // Count consecutive request cycles; clear whenever not requesting.
    always_ff @(posedge clk) begin
        if (reset)
            cnt <= '0;
        else if (in_req)
            cnt <= cnt + 1'b1;
        else
            cnt <= '0;
    end

    // Sticky error flag.
    always_ff @(posedge clk) begin
        if (reset)
            err <= 1'b0;
        else if (timeout)
            err <= 1'b1;
    end

endmodule

// File: rtl/mem_access_unit.sv
// Memory access stage: converts the Controller's level MemRead/MemWrite
// commands into a req/ack transaction, holds IR and MDR, and decodes the
// IR fields. Optional request watchdog enabled by defining MAU_TIMEOUT_EN.
//
// Memory handshake: mem_req is held high together with stable mem_addr,
// mem_wdata and mem_we from the cycle after a command is accepted until the
// cycle in which memory returns a one-cycle mem_ack pulse (read data valid
// in that same cycle). mem_req then stays low for at least one cycle before
// the next request. mem_ack while mem_req is low is ignored.
module mem_access_unit
    import cpu_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic              IorD,
    input  logic              IRWrite,
    input  logic [ADDR_W-1:0] PC,
    input  logic [ADDR_W-1:0] ALUOut,
    input  logic [DATA_W-1:0] WriteData,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_req,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              Stall,
    output logic              mem_err,
    output logic [DATA_W-1:0] IR,
    output logic [DATA_W-1:0] MDR,
    output logic [5:0]        OpCode,
    output logic [5:0]        Funct,
    output logic [4:0]        Rs,
    output logic [4:0]        Rt,
    output logic [4:0]        Rd,
    output logic [4:0]        Shamt,
    output logic [15:0]       Imm16,
    output logic [25:0]       JTarget
);

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_REQ  = REQ;
    localparam logic [1:0] ST_DONE = DONE;

    logic [1:0] state;
    acc_kind_t  kind;
    logic       in_req;
    logic       cmd;
    logic       timeout;

    assign in_req  = (state == ST_REQ);
    assign cmd     = MemRead || MemWrite;
    assign mem_req = in_req;
    // Combinational so the Controller freezes in the issuing cycle.
    assign Stall   = ((state == ST_IDLE) && cmd) || in_req;

    // Transaction FSM: capture command in IDLE, hold in REQ until ack or
    // timeout, one-cycle DONE gap before the next command is accepted.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_we    <= 1'b0;
            kind      <= ACC_MDR;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd) begin
                        mem_addr  <= IorD ? ALUOut : PC;
                        mem_wdata <= WriteData;
                        mem_we    <= MemWrite;
                        kind      <= decode_kind(MemWrite, IRWrite);
                        state     <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (mem_ack || timeout)
                        state <= ST_DONE;
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // IR / MDR load only on an ack accepted while requesting a read.
    always_ff @(posedge clk) begin
        if (reset) begin
            IR  <= '0;
            MDR <= '0;
        end else if (in_req && mem_ack) begin
            if (kind == ACC_IR)
                IR <= mem_rdata;
            else if (kind == ACC_MDR)
                MDR <= mem_rdata;
        end
    end

`ifdef MAU_TIMEOUT_EN
    mau_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .in_req  (in_req),
        .ack     (mem_ack),
        .timeout (timeout),
        .err     (mem_err)
    );
`else
    assign timeout = 1'b0;
    assign mem_err = 1'b0;
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

    // Field decode is pure wiring from IR.
    assign OpCode  = IR[IR_OP_HI:IR_OP_LO];
    assign Rs      = IR[IR_RS_HI:IR_RS_LO];
    assign Rt      = IR[IR_RT_HI:IR_RT_LO];
    assign Rd      = IR[IR_RD_HI:IR_RD_LO];
    assign Shamt   = IR[IR_SHAMT_HI:IR_SHAMT_LO];
    assign Funct   = IR[IR_FUNCT_HI:IR_FUNCT_LO];
    assign Imm16   = IR[IR_IMM_HI:0];
    assign JTarget = IR[IR_JT_HI:0];

endmodule
